// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic-array sequencer: FSM state encoding and pipeline latency.
package sa_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Cycles from an activation entering row 0 to its psum leaving the bottom row.
  function automatic int unsigned sa_lat(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// 1-bit serial-in, parallel-out delay line with synchronous active-low reset.
module sa_skew_line #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [DEPTH-1:0] q
);

  logic [DEPTH-1:0] q_q, q_d;

  always_comb begin
    q_d = DEPTH'({q_q, din});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/sa_ctrl.sv
// Weight-stationary systolic-array sequencer: weight load, skewed activation stream, drain.
// Optional SA_CTRL_PERF_EN adds per-job cycle and stall counters. Assumes ROWS >= 2.
module sa_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LEN_W-1:0]         num_vec,
  input  logic                     act_valid,
  output logic                     act_ready,
  output logic                     w_load_en,
  output logic [$clog2(ROWS)-1:0]  w_row_sel,
  output logic [ROWS-1:0]          row_en,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done
`ifdef SA_CTRL_PERF_EN
  ,
  output logic [31:0]              perf_cycles,
  output logic [31:0]              perf_stalls
`endif
);

  localparam int unsigned LAT   = sa_lat(ROWS, COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [LEN_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [LEN_W-1:0] num_vec_q, num_vec_d;
  logic             act_ready_q, act_ready_d;
  logic             w_load_en_q, w_load_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fire_c;
  logic [ROWS-2:0]  skew_q;
  logic [LAT-1:0]   ov_line;

  assign fire_c    = act_valid & act_ready_q;
  assign row_en    = {skew_q, fire_c};
  assign out_valid = ov_line[LAT-1];
  assign w_row_sel = row_cnt_q;
  assign act_ready = act_ready_q;
  assign w_load_en = w_load_en_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    state_d   = state_q;
    row_cnt_d = '0;
    vec_cnt_d = vec_cnt_q;
    num_vec_d = num_vec_q;
    case (state_q)
      IDLE: begin
        vec_cnt_d = '0;
        if (start) begin
          if (num_vec != '0) begin
            num_vec_d = num_vec;
            state_d   = LOAD_W;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD_W: begin
        if (row_cnt_q == ROW_W'(ROWS - 1)) state_d = STREAM;
        else row_cnt_d = ROW_W'(row_cnt_q + 1'b1);
      end
      STREAM: begin
        if (fire_c) begin
          vec_cnt_d = LEN_W'(vec_cnt_q + 1'b1);
          if (vec_cnt_d == num_vec_q) state_d = DRAIN;
        end
      end
      // Leave once only the final out_valid stage can still hold a token.
      DRAIN: begin
        if (ov_line[LAT-2:0] == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    act_ready_d = (state_d == STREAM);
    w_load_en_d = (state_d == LOAD_W);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      vec_cnt_q   <= '0;
      num_vec_q   <= '0;
      act_ready_q <= 1'b0;
      w_load_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      vec_cnt_q   <= vec_cnt_d;
      num_vec_q   <= num_vec_d;
      act_ready_q <= act_ready_d;
      w_load_en_q <= w_load_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  sa_skew_line #(.DEPTH(ROWS - 1)) u_row_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (fire_c),
    .q     (skew_q)
  );

  sa_skew_line #(.DEPTH(LAT)) u_ov_line (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (fire_c),
    .q     (ov_line)
  );

`ifdef SA_CTRL_PERF_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Running counts are published and cleared in the DONE cycle, which itself counts.
  always_comb begin
    cyc_cnt_d     = cyc_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (state_q != IDLE) cyc_cnt_d = 32'(cyc_cnt_q + 1'b1);
    if (state_q == STREAM && !act_valid) stall_cnt_d = 32'(stall_cnt_q + 1'b1);
    if (state_q == DONE) begin
      perf_cycles_d = 32'(cyc_cnt_q + 1'b1);
      perf_stalls_d = stall_cnt_q;
      cyc_cnt_d     = '0;
      stall_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt_q     <= '0;
      stall_cnt_q   <= '0;
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      cyc_cnt_q     <= cyc_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule
